// File: rtl/tone_prescaler.sv
// -----------------------------------------------------------------------------
// tone_prescaler
//
// Note-rate strobe generator feeding the sine-table address counter. A note
// (code + duration) is taken over a valid/ready handshake; while it plays,
// tone_en pulses once every DIV[code] cycles so that a TABLE_SIZE-entry sine
// table is swept once per note period. Duration is counted in tick_1ms
// strobes and completion is reported with a one-cycle done pulse.
//
// Optional feature: define TONE_GAP_EN to append 8 ticks of silence (GAP
// state) after every played note, before done is pulsed.
//
// Ports:
//   clk         system clock
//   resetN      asynchronous active-low reset
//   note_valid  note request valid
//   note_ready  block can accept a note (high in IDLE)
//   note_code   0 = rest, 1..15 = C4..D5 chromatic
//   dur_ticks   note length in 1 ms ticks (0 = complete immediately)
//   tick_1ms    one-cycle 1 ms strobe from the system timebase
//   stop        synchronous abort of the current note / gap
//   tone_en     one-cycle strobe to the downstream counter enable
//   playing     note, rest or gap in progress
//   done        one-cycle pulse when a note ends
// -----------------------------------------------------------------------------
module tone_prescaler #(
   parameter int CLK_HZ     = 50000000,
   parameter int TABLE_SIZE = 256,
   parameter int DIV_W      = 16,
   parameter int DUR_W      = 8
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             note_valid,
   output logic             note_ready,
   input  logic [3:0]       note_code,
   input  logic [DUR_W-1:0] dur_ticks,
   input  logic             tick_1ms,
   input  logic             stop,
   output logic             tone_en,
   output logic             playing,
   output logic             done
);

   // Note frequencies in Hz, C4..D5 chromatic; code 0 is a rest.
   function automatic int note_hz(input int k);
      case (k)
         1:       return 262;
         2:       return 277;
         3:       return 294;
         4:       return 311;
         5:       return 330;
         6:       return 349;
         7:       return 370;
         8:       return 392;
         9:       return 415;
         10:      return 440;
         11:      return 466;
         12:      return 494;
         13:      return 523;
         14:      return 554;
         15:      return 587;
         default: return 0;
      endcase
   endfunction

   // Rounded integer divide, evaluated at elaboration only.
   function automatic longint div_of(input int k);
      longint den;
      den = longint'(TABLE_SIZE) * longint'(note_hz(k));
      if (den == 0) return 0;
      return (longint'(CLK_HZ) + den / 2) / den;
   endfunction

   // Divide ROM: constant per code, range-checked against DIV_W.
   logic [DIV_W-1:0] div_rom [16];

   for (genvar k = 0; k < 16; k++) begin : g_rom
      localparam longint DV = div_of(k);
      if (k != 0 && (DV < 1 || DV >= (longint'(1) << DIV_W))) begin : g_bad
         $error("tone_prescaler: DIV[%0d]=%0d does not fit in DIV_W=%0d bits",
                k, DV, DIV_W);
      end
      assign div_rom[k] = DIV_W'(DV);
   end

`ifdef TONE_GAP_EN
   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
   logic [2:0]       gap_cnt, gap_cnt_d;
`else
   typedef enum logic [1:0] {IDLE, PLAY} state_t;
`endif

   state_t           state, state_d;
   logic [DIV_W-1:0] div_cnt, div_cnt_d;
   logic [DIV_W-1:0] div_last;
   logic [DUR_W-1:0] dur_cnt, dur_cnt_d;
   logic [3:0]       div_sel, div_sel_d;
   logic             tone_en_d, done_d;
   logic             strobe;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state   <= IDLE;
         div_cnt <= '0;
         dur_cnt <= '0;
         div_sel <= '0;
         tone_en <= 1'b0;
         done    <= 1'b0;
`ifdef TONE_GAP_EN
         gap_cnt <= '0;
`endif
      end else begin
         state   <= state_d;
         div_cnt <= div_cnt_d;
         dur_cnt <= dur_cnt_d;
         div_sel <= div_sel_d;
         tone_en <= tone_en_d;
         done    <= done_d;
`ifdef TONE_GAP_EN
         gap_cnt <= gap_cnt_d;
`endif
      end
   end

   // -------------------------------------------------- next state / outputs
   always_comb begin
      state_d   = state;
      div_cnt_d = div_cnt;
      dur_cnt_d = dur_cnt;
      div_sel_d = div_sel;
      tone_en_d = 1'b0;
      done_d    = 1'b0;
`ifdef TONE_GAP_EN
      gap_cnt_d = gap_cnt;
`endif

      div_last = div_rom[div_sel] - DIV_W'(1);
      // Rests never strobe; their divider stays parked at 0.
      strobe   = (div_sel != 4'd0) && (div_cnt == div_last);

      case (state)
         IDLE: begin
            // stop outranks a request arriving in the same cycle.
            if (note_valid && !stop) begin
               div_sel_d = note_code;
               dur_cnt_d = dur_ticks;
               div_cnt_d = '0;
               if (dur_ticks == '0) done_d  = 1'b1;
               else                 state_d = PLAY;
            end
         end

         PLAY: begin
            if (stop) begin
               state_d   = IDLE;
               div_cnt_d = '0;
               dur_cnt_d = '0;
               done_d    = 1'b1;
            end else begin
               // A strobe that lands on the expiry edge is still issued.
               tone_en_d = strobe;
               if (div_sel != 4'd0)
                  div_cnt_d = strobe ? '0 : div_cnt + DIV_W'(1);
               if (tick_1ms) begin
                  if (dur_cnt == DUR_W'(1)) begin
                     dur_cnt_d = '0;
                     div_cnt_d = '0;
`ifdef TONE_GAP_EN
                     state_d   = GAP;
                     gap_cnt_d = '0;
`else
                     state_d   = IDLE;
                     done_d    = 1'b1;
`endif
                  end else begin
                     dur_cnt_d = dur_cnt - DUR_W'(1);
                  end
               end
            end
         end

`ifdef TONE_GAP_EN
         GAP: begin
            // Eight ticks of silence; the tick that ended PLAY is not one.
            if (stop) begin
               state_d   = IDLE;
               gap_cnt_d = '0;
               done_d    = 1'b1;
            end else if (tick_1ms) begin
               if (gap_cnt == 3'd7) begin
                  state_d   = IDLE;
                  gap_cnt_d = '0;
                  done_d    = 1'b1;
               end else begin
                  gap_cnt_d = gap_cnt + 3'd1;
               end
            end
         end
`endif

         default: state_d = IDLE;
      endcase
   end

   // Status follows the registered state, so the cycle that enters IDLE
   // already shows note_ready=1 / playing=0 alongside the done pulse.
   assign note_ready = (state == IDLE);
   assign playing    = (state != IDLE);

endmodule

// File: tb/tb_tone_prescaler.sv
// -----------------------------------------------------------------------------
// tb_tone_prescaler
//
// Directed + randomized bench for tone_prescaler. Expected outputs per cycle
// come from a closed-form model of a note: accept edge n=0, ticks every
// `period` cycles, strobes at multiples of DIV, end edge derived from the
// duration, optional gap and optional stop. Works with or without
// TONE_GAP_EN defined.
// -----------------------------------------------------------------------------
module tb_tone_prescaler;
   localparam int DUR_W = 8;

`ifdef TONE_GAP_EN
   localparam int GAP_TICKS = 8;
`else
   localparam int GAP_TICKS = 0;
`endif

   logic             clk        = 1'b0;
   logic             resetN     = 1'b0;
   logic             note_valid = 1'b0;
   logic [3:0]       note_code  = 4'd0;
   logic [DUR_W-1:0] dur_ticks  = '0;
   logic             tick_1ms   = 1'b0;
   logic             stop       = 1'b0;
   logic             note_ready, tone_en, playing, done;

   int vectors     = 0;
   int miscompares = 0;

   tone_prescaler #(
      .CLK_HZ    (50000000),
      .TABLE_SIZE(256),
      .DIV_W     (16),
      .DUR_W     (DUR_W)
   ) dut (
      .clk       (clk),
      .resetN    (resetN),
      .note_valid(note_valid),
      .note_ready(note_ready),
      .note_code (note_code),
      .dur_ticks (dur_ticks),
      .tick_1ms  (tick_1ms),
      .stop      (stop),
      .tone_en   (tone_en),
      .playing   (playing),
      .done      (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish within time budget");
      $fatal(1, "watchdog");
   end

   // Reference divider from the note frequency in floating point.
   function automatic int ref_div(input int code);
      int hz [16];
      hz = '{0, 262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494, 523, 554, 587};
      if (code == 0) return 0;
      return $rtoi(50000000.0 / (256.0 * real'(hz[code])) + 0.5);
   endfunction

   task automatic chk(input string tag, input int n, input logic obs, input logic want);
      vectors++;
      assert (obs === want) else begin
         miscompares++;
         $error("FAIL %s n=%0d: observed %0b expected %0b", tag, n, obs, want);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int want);
      vectors++;
      assert (obs == want) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
      end
   endtask

   task automatic chk_idle(input string tag, input int n);
      chk({tag, ".tone_en"},    n, tone_en,    1'b0);
      chk({tag, ".done"},       n, done,       1'b0);
      chk({tag, ".playing"},    n, playing,    1'b0);
      chk({tag, ".note_ready"}, n, note_ready, 1'b1);
   endtask

   // One note from accept to two cycles past its end. stop_at = 0 means no
   // stop. Called and returns on a negative clock edge.
   task automatic play_note(input string name, input int code, input int dur,
                            input int period, input int stop_at, input bit tick_acc);
      int  d, e_dur, e_end, last, n_obs, done_obs;
      bit  stopped, exp_te, exp_play;
      d       = ref_div(code);
      e_dur   = dur * period;
      stopped = (dur != 0) && (stop_at > 0) && (stop_at <= e_dur + GAP_TICKS * period);
      if (dur == 0)     e_end = 0;
      else if (stopped) e_end = stop_at;
      else              e_end = e_dur + GAP_TICKS * period;
      last     = (stopped && stop_at - 1 < e_dur) ? stop_at - 1 : e_dur;
      n_obs    = 0;
      done_obs = 0;

      for (int n = 0; n <= e_end + 2; n++) begin
         if (n == 0) begin
            note_valid = 1'b1;
            note_code  = 4'(code);
            dur_ticks  = DUR_W'(dur);
            tick_1ms   = tick_acc;
            stop       = 1'b0;
         end else begin
            // Requests while busy must be ignored.
            note_valid = (n <= e_end) ? 1'($urandom_range(0, 1)) : 1'b0;
            note_code  = 4'($urandom_range(0, 15));
            dur_ticks  = DUR_W'($urandom_range(0, 255));
            tick_1ms   = (n % period == 0);
            stop       = (n == stop_at);
         end
         @(posedge clk);
         @(negedge clk);
         exp_te   = (code != 0) && (dur != 0) && (n >= 1) && (n <= last) && (n % d == 0);
         exp_play = (dur != 0) && (n < e_end);
         chk({name, ".tone_en"},    n, tone_en,    exp_te);
         chk({name, ".done"},       n, done,       (n == e_end));
         chk({name, ".playing"},    n, playing,    exp_play);
         chk({name, ".note_ready"}, n, note_ready, !exp_play);
         n_obs    += int'(tone_en);
         done_obs += int'(done);
      end
      note_valid = 1'b0;
      tick_1ms   = 1'b0;
      stop       = 1'b0;
      chk_int({name, ".strobes"}, n_obs, (code != 0 && dur != 0) ? last / d : 0);
      chk_int({name, ".dones"},   done_obs, 1);
   endtask

   initial begin
      int code, dur, period, stop_at, at;

      // Reset and idle.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_idle("in_reset", i);
      end
      resetN = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk_idle("idle", i);
      end

      // A4 for 3 ticks (scaled tick period), tick on the accept cycle ignored.
      play_note("a4", 10, 3, 1500, 0, 1'b1);
      // Rest: no strobes, duration still counts.
      play_note("rest", 0, 2, 800, 0, 1'b0);
      // Zero duration completes at once.
      play_note("dur0", $urandom_range(0, 15), 0, 500, 0, 1'b0);
      // Stop 1000 cycles into C4 (DIV 745): exactly one strobe.
      play_note("stop_c4", 1, 4, 2000, 1000, 1'b0);

      // stop in IDLE outranks note_valid in the same cycle.
      note_valid = 1'b1;
      note_code  = 4'd5;
      dur_ticks  = DUR_W'(5);
      stop       = 1'b1;
      @(posedge clk);
      @(negedge clk);
      note_valid = 1'b0;
      stop       = 1'b0;
      for (int i = 0; i < 20; i++) begin
         chk_idle("stop_idle", i);
         @(negedge clk);
      end

      // C5 for one tick: strobes, then gap silence when enabled.
      play_note("c5", 13, 1, 600, 0, 1'b0);

      // Randomized notes, some stopped part way.
      for (int i = 0; i < 3; i++) begin
         code    = $urandom_range(0, 15);
         dur     = $urandom_range(1, 3);
         period  = $urandom_range(300, 700);
         stop_at = ($urandom_range(0, 1) == 1) ?
                   $urandom_range(1, (dur + GAP_TICKS) * period) : 0;
         play_note($sformatf("rnd%0d", i), code, dur, period, stop_at,
                   1'($urandom_range(0, 1)));
      end

      // Reset mid-note (mid-gap when the gap exists): immediate reset values,
      // no done pulse afterwards.
      dur        = (GAP_TICKS > 0) ? 1 : 3;
      at         = (GAP_TICKS > 0) ? 2100 : 900;
      note_valid = 1'b1;
      note_code  = 4'd13;
      dur_ticks  = DUR_W'(dur);
      @(posedge clk);
      @(negedge clk);
      note_valid = 1'b0;
      for (int n = 1; n <= at; n++) begin
         tick_1ms = (n % 600 == 0);
         @(posedge clk);
         @(negedge clk);
      end
      tick_1ms = 1'b0;
      chk("pre_reset.playing", at, playing, 1'b1);
      #2 resetN = 1'b0;
      #1 chk_idle("async_reset", 0);
      @(negedge clk);
      @(negedge clk);
      resetN = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk_idle("post_reset", i);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
